// File: rtl/barcode_rdr.sv
// barcode_rdr: serial station-barcode decoder.
// The width of the start pulse sets the sample point for the eight data bits.
// Each data bit is sampled one start-pulse width after its falling edge.
// A frame whose top two bits are 00 is loaded into ID, and ID_vld is raised.
// Optional feature: define BC_TIMEOUT_EN to abort a frame whose next falling
// edge does not arrive within 4x the calibrated period.
module barcode_rdr #(
  parameter int CNT_W = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEAS,
    S_WAIT_FALL,
    S_TIME,
    S_CHECK
  } state_t;

  // Line conditioning: two synchronizer flops plus one delay flop for edges.
  logic bc_meta_q, bc_sync_q, bc_dly_q;
  logic fall, rise;

  // Frame decode state.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shft_q, shft_d;
  logic [7:0]       id_q, id_d;
  logic             id_vld_q, id_vld_d;

  logic [CNT_W-1:0] timer_inc;

  assign fall = bc_dly_q & ~bc_sync_q;
  assign rise = ~bc_dly_q & bc_sync_q;

  // The timer saturates, so a stuck-low line cannot wrap it back to a short period.
  assign timer_inc = (&timer_q) ? timer_q : timer_q + CNT_W'(1);

`ifdef BC_TIMEOUT_EN
  // Abort limit is 4x period, computed wide and clamped to the timer range.
  logic [CNT_W+1:0] limit_wide;
  logic [CNT_W-1:0] limit;
  logic             timeout;

  assign limit_wide = {period_q, 2'b00};
  assign limit      = (|limit_wide[CNT_W+1:CNT_W]) ? '1 : limit_wide[CNT_W-1:0];
  assign timeout    = (timer_q >= limit);
`endif

  // Next-state and datapath decisions for the frame decoder.
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves a variable unassigned, which would infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    period_d  = period_q;
    bit_cnt_d = bit_cnt_q;
    shft_d    = shft_q;
    id_d      = id_q;
    id_vld_d  = id_vld_q & ~clr_ID_vld;

    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          timer_d = '0;
          state_d = S_MEAS;
        end
      end

      S_MEAS: begin
        timer_d = timer_inc;
        if (rise) begin
          period_d  = timer_q;
          bit_cnt_d = '0;
          timer_d   = '0;
          state_d   = S_WAIT_FALL;
        end
      end

      S_WAIT_FALL: begin
`ifdef BC_TIMEOUT_EN
        timer_d = timer_inc;
`endif
        if (fall) begin
          timer_d = '0;
          state_d = S_TIME;
        end
`ifdef BC_TIMEOUT_EN
        else if (timeout) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
`endif
      end

      S_TIME: begin
        timer_d = timer_inc;
        if (timer_q == period_q) begin
          shft_d    = {shft_q[6:0], bc_sync_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          timer_d   = '0;
          state_d   = (bit_cnt_q == 3'd7) ? S_CHECK : S_WAIT_FALL;
        end
      end

      S_CHECK: begin
        // A set here overrides a simultaneous clear from the core.
        if (shft_q[7:6] == 2'b00) begin
          id_d     = shft_q;
          id_vld_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Registers, including the synchronizer chain, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      bc_meta_q <= 1'b1;
      bc_sync_q <= 1'b1;
      bc_dly_q  <= 1'b1;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      period_q  <= '0;
      bit_cnt_q <= '0;
      shft_q    <= '0;
      id_q      <= '0;
      id_vld_q  <= 1'b0;
    end else begin
      bc_meta_q <= BC;
      bc_sync_q <= bc_meta_q;
      bc_dly_q  <= bc_sync_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      bit_cnt_q <= bit_cnt_d;
      shft_q    <= shft_d;
      id_q      <= id_d;
      id_vld_q  <= id_vld_d;
    end
  end

  assign ID     = id_q;
  assign ID_vld = id_vld_q;

endmodule
